simt_sm: RTL and testbench

- Simplified SIMT streaming multiprocessor. Holds per-warp program memories, a banked per-lane register file, a shared scratchpad and a line-organised global memory.
- Issues one whole-warp instruction per cycle, with all active lanes executing in parallel.
- Top-level compute block. Programs, data and warp state are loaded by backdoor.
- Raises `done` when every warp has exited.

---
 rtl/simt_sm.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_simt_sm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/simt_sm.sv
`default_nettype none
// ============================================================================
//  Module      : simt_sm (with simt_pkg, simt_rf, simt_gmem)
//  Description : Simplified SIMT streaming multiprocessor. One whole-warp
//                instruction issues per cycle from a round-robin scheduler and
//                commits on the same edge across all active lanes. Program
//                memory, register file, shared and global memories are loaded
//                by hierarchical backdoor access.
//  Ports       : clk  in  1  clock, all logic on the rising edge
//                rst  in  1  synchronous active-high reset
//                done out 1  every warp has exited; sticky until reset
//  Revision    : 1.0  initial release
// ============================================================================

package simt_pkg;
    typedef enum logic [1:0] {
        W_READY = 2'd0,
        W_BAR   = 2'd1,
        W_EXIT  = 2'd2
    } warp_state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_LDR  = 8'h10;
    localparam logic [7:0] OP_STR  = 8'h11;
    localparam logic [7:0] OP_LDS  = 8'h12;
    localparam logic [7:0] OP_STS  = 8'h13;
    localparam logic [7:0] OP_BAR  = 8'h25;
    localparam logic [7:0] OP_TID  = 8'h26;
    localparam logic [7:0] OP_AND  = 8'h50;
    localparam logic [7:0] OP_XOR  = 8'h52;
    localparam logic [7:0] OP_SHL  = 8'h60;
    localparam logic [7:0] OP_SHR  = 8'h61;
    localparam logic [7:0] OP_EXIT = 8'hFF;
endpackage

// ----------------------------------------------------------------------------
// Banked per-lane register file. Bank = reg[1:0], row = reg[5:2]. Each lane
// owns its own storage, so all lanes write in parallel without conflict.
// ----------------------------------------------------------------------------
module simt_rf #(
    parameter int WARP_SIZE = 32,
    parameter int NUM_WARPS = 24,
    parameter int NUM_REGS  = 64,
    parameter int WARP_BITS = 5
) (
    input  logic                     clk,
    input  logic [WARP_BITS-1:0]     warp,
    input  logic [5:0]               rs1_idx,
    input  logic [5:0]               rs2_idx,
    input  logic [5:0]               rd_idx,
    input  logic [WARP_SIZE-1:0]     wr_en,
    input  logic [WARP_SIZE*32-1:0]  wr_data,
    output logic [WARP_SIZE*32-1:0]  rs1_data,
    output logic [WARP_SIZE*32-1:0]  rs2_data
);
    localparam int BANK_DEPTH = NUM_REGS / 4;

    logic [31:0] rf_bank_phys [4][WARP_SIZE][NUM_WARPS][BANK_DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < WARP_SIZE; l++) begin
            if (wr_en[l]) begin
                rf_bank_phys[rd_idx[1:0]][l][warp][rd_idx[5:2]] <= wr_data[l*32 +: 32];
            end
        end
    end

    for (genvar l = 0; l < WARP_SIZE; l++) begin : g_read
        assign rs1_data[l*32 +: 32] = rf_bank_phys[rs1_idx[1:0]][l][warp][rs1_idx[5:2]];
        assign rs2_data[l*32 +: 32] = rf_bank_phys[rs2_idx[1:0]][l][warp][rs2_idx[5:2]];
    end
endmodule

// ----------------------------------------------------------------------------
// Line-organised global memory: 2^ADDR_WIDTH lines of 32 words. One read and
// one write port per lane. Writes are applied in ascending lane order so the
// highest lane wins when several lanes hit the same word.
// ----------------------------------------------------------------------------
module simt_gmem #(
    parameter int ADDR_WIDTH = 10,
    parameter int WARP_SIZE  = 32
) (
    input  logic                     clk,
    input  logic [WARP_SIZE*32-1:0]  addr,
    input  logic [WARP_SIZE-1:0]     wr_en,
    input  logic [WARP_SIZE*32-1:0]  wr_data,
    output logic [WARP_SIZE*32-1:0]  rd_data
);
    logic [1023:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < WARP_SIZE; l++) begin
            if (wr_en[l]) begin
                mem[addr[l*32+7 +: ADDR_WIDTH]][{addr[l*32+2 +: 5], 5'b00000} +: 32]
                    <= wr_data[l*32 +: 32];
            end
        end
    end

    for (genvar l = 0; l < WARP_SIZE; l++) begin : g_port
        logic [ADDR_WIDTH-1:0] line;
        logic [4:0]            word;
        logic                  unused_addr_bits;
        assign line = addr[l*32+7 +: ADDR_WIDTH];
        assign word = addr[l*32+2 +: 5];
        assign rd_data[l*32 +: 32] = mem[line][{word, 5'b00000} +: 32];
        // Upper address bits wrap and the byte offset is ignored.
        assign unused_addr_bits = ^{addr[l*32+ADDR_WIDTH+7 +: 25-ADDR_WIDTH], addr[l*32 +: 2]};
    end
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module simt_sm
    import simt_pkg::*;
#(
    parameter int WARP_SIZE              = 32,
    parameter int NUM_WARPS              = 24,
    parameter int NUM_REGS               = 64,
    parameter int DIVERGENCE_STACK_DEPTH = 32,
    parameter int RETURN_STACK_DEPTH     = 8,
    parameter int ADDR_WIDTH             = 10,
    parameter int MAX_PENDING_PER_WARP   = 64,
    parameter int SM_ID                  = 0
) (
    input  logic clk,
    input  logic rst,
    output logic done
);
    localparam int WARP_BITS = $clog2(NUM_WARPS);

    // Backdoor-visible state
    logic [63:0]          prog_mem [NUM_WARPS][256];
    warp_state_t          warp_state [NUM_WARPS];
    warp_state_t          warp_state_nxt [NUM_WARPS];
    logic [7:0]           warp_pc [NUM_WARPS];
    logic [WARP_SIZE-1:0] warp_active_mask [NUM_WARPS];
    logic [31:0]          warp_reg_writes [NUM_WARPS];
    logic [31:0]          cycle;
    logic [31:0]          shared_mem [1024];

    // Scheduler
    logic [WARP_BITS-1:0] r_last_warp;
    logic [WARP_BITS-1:0] w_issue_warp;
    logic                 w_issue_valid;
    int                   w_sched_cand;
    logic                 w_any_ready;
    logic                 w_any_bar;
    logic                 w_all_exit;
    logic                 w_bar_release;

    // Decode
    logic [63:0]          w_inst;
    logic [7:0]           w_op;
    logic [5:0]           w_rd;
    logic [5:0]           w_rs1;
    logic [5:0]           w_rs2;
    logic [31:0]          w_imm;
    logic                 w_reg_write_op;
    logic [WARP_SIZE-1:0] w_cur_mask;

    // Lane datapath buses
    logic [WARP_SIZE*32-1:0] w_rs1_data;
    logic [WARP_SIZE*32-1:0] w_rs2_data;
    logic [WARP_SIZE*32-1:0] w_res_data;
    logic [WARP_SIZE*32-1:0] w_lane_addr;
    logic [WARP_SIZE*32-1:0] w_gmem_rdata;

    logic [31:0] unused_params;
    logic        unused_fields;
    assign unused_params = 32'(DIVERGENCE_STACK_DEPTH + RETURN_STACK_DEPTH
                               + MAX_PENDING_PER_WARP + SM_ID);
    assign unused_fields = ^{w_inst[55:54], w_inst[47:46], w_inst[39:38], w_inst[31:20]};

    // Round-robin pick of the first ready warp after the last issued one.
    always_comb begin
        w_issue_valid = 1'b0;
        w_issue_warp  = '0;
        w_sched_cand  = 0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            w_sched_cand = int'(r_last_warp) + k;
            if (w_sched_cand >= NUM_WARPS) begin
                w_sched_cand = w_sched_cand - NUM_WARPS;
            end
            if (!w_issue_valid && warp_state[w_sched_cand] == W_READY) begin
                w_issue_valid = 1'b1;
                w_issue_warp  = WARP_BITS'(w_sched_cand);
            end
        end
    end

    // With three states, "no warp ready" means every live warp waits at the
    // barrier; if none is waiting either, all have exited.
    always_comb begin
        w_any_ready = 1'b0;
        w_any_bar   = 1'b0;
        w_all_exit  = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (warp_state[w] == W_READY) w_any_ready = 1'b1;
            if (warp_state[w] == W_BAR)   w_any_bar   = 1'b1;
            if (warp_state[w] != W_EXIT)  w_all_exit  = 1'b0;
        end
    end
    assign w_bar_release = !w_any_ready && w_any_bar;

    // Decode; the opcode is forced to NOP when nothing issues or in reset so
    // that no lane side effect can occur.
    assign w_inst  = prog_mem[w_issue_warp][warp_pc[w_issue_warp]];
    assign w_op    = (w_issue_valid && !rst) ? w_inst[63:56] : OP_NOP;
    assign w_rd    = w_inst[53:48];
    assign w_rs1   = w_inst[45:40];
    assign w_rs2   = w_inst[37:32];
    assign w_imm   = {{12{w_inst[19]}}, w_inst[19:0]};
    assign w_cur_mask = warp_active_mask[w_issue_warp];
    assign w_reg_write_op = w_op inside {OP_ADD, OP_MUL, OP_AND, OP_XOR, OP_SHL,
                                         OP_SHR, OP_LDR, OP_LDS, OP_TID};

    simt_rf #(
        .WARP_SIZE (WARP_SIZE),
        .NUM_WARPS (NUM_WARPS),
        .NUM_REGS  (NUM_REGS),
        .WARP_BITS (WARP_BITS)
    ) oc_inst (
        .clk      (clk),
        .warp     (w_issue_warp),
        .rs1_idx  (w_rs1),
        .rs2_idx  (w_rs2),
        .rd_idx   (w_rd),
        .wr_en    (w_reg_write_op ? w_cur_mask : '0),
        .wr_data  (w_res_data),
        .rs1_data (w_rs1_data),
        .rs2_data (w_rs2_data)
    );

    simt_gmem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WARP_SIZE  (WARP_SIZE)
    ) dut_memory (
        .clk     (clk),
        .addr    (w_lane_addr),
        .wr_en   ((w_op == OP_STR) ? w_cur_mask : '0),
        .wr_data (w_rs2_data),
        .rd_data (w_gmem_rdata)
    );

    for (genvar l = 0; l < WARP_SIZE; l++) begin : g_lane
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] addr;
        logic [31:0] res;
        assign a    = w_rs1_data[l*32 +: 32];
        // A non-zero immediate replaces the second register operand.
        assign b    = (w_imm != 32'd0) ? w_imm : w_rs2_data[l*32 +: 32];
        assign addr = a + w_imm;
        always_comb begin
            res = '0;
            case (w_op)
                OP_ADD:  res = a + b;
                OP_MUL:  res = a * b;
                OP_AND:  res = a & b;
                OP_XOR:  res = a ^ b;
                OP_SHL:  res = a << b[4:0];
                OP_SHR:  res = a >> b[4:0];
                OP_LDR:  res = w_gmem_rdata[l*32 +: 32];
                OP_LDS:  res = shared_mem[addr[11:2]];
                OP_TID:  res = 32'(l);
                default: res = '0;
            endcase
        end
        assign w_res_data[l*32 +: 32]  = res;
        assign w_lane_addr[l*32 +: 32] = addr;
    end

    // Shared memory stores; ascending lane order makes the highest lane win.
    always_ff @(posedge clk) begin
        if (w_op == OP_STS) begin
            for (int l = 0; l < WARP_SIZE; l++) begin
                if (w_cur_mask[l]) begin
                    shared_mem[w_lane_addr[l*32+2 +: 10]] <= w_rs2_data[l*32 +: 32];
                end
            end
        end
    end

    // Warp state machine: next state
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_state_nxt[w] = warp_state[w];
        end
        if (w_op == OP_BAR) begin
            warp_state_nxt[w_issue_warp] = W_BAR;
        end else if (w_op == OP_EXIT) begin
            warp_state_nxt[w_issue_warp] = W_EXIT;
        end
        if (w_bar_release) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (warp_state[w] == W_BAR) warp_state_nxt[w] = W_READY;
            end
        end
    end

    // Warp state machine: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                warp_state[w] <= W_READY;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                warp_state[w] <= warp_state_nxt[w];
            end
        end
    end

    // Per-warp counters, cycle counter and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                warp_pc[w]          <= 8'd0;
                warp_active_mask[w] <= '1;
                warp_reg_writes[w]  <= 32'd0;
            end
            cycle       <= 32'd0;
            done        <= 1'b0;
            // Start just before warp 0 so it is the first to issue.
            r_last_warp <= WARP_BITS'(NUM_WARPS - 1);
        end else begin
            cycle <= cycle + 32'd1;
            if (w_all_exit) begin
                done <= 1'b1;
            end
            if (w_issue_valid) begin
                r_last_warp           <= w_issue_warp;
                warp_pc[w_issue_warp] <= warp_pc[w_issue_warp] + 8'd1;
                if (w_reg_write_op) begin
                    warp_reg_writes[w_issue_warp] <= warp_reg_writes[w_issue_warp] + 32'd1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_simt_sm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simt_sm
//  Description : Directed self-checking bench for simt_sm: reset state, ALU
//                ops, barrier ordering, lane masking, tiled 8x8 matmul on two
//                warps, done stickiness and mid-run reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_simt_sm;
    import simt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done;
    int   tests = 0;
    int   fails = 0;

    simt_sm dut (
        .clk  (clk),
        .rst  (rst),
        .done (done)
    );

    always #5 clk = ~clk;

    // pg/rs3 carry junk on purpose: they must be ignored.
    function automatic logic [63:0] enc(input logic [7:0] op, input logic [5:0] rd,
                                        input logic [5:0] rs1, input logic [5:0] rs2,
                                        input logic [19:0] imm);
        return {op, 2'b00, rd, 2'b00, rs1, 2'b00, rs2, 4'h5, 8'h3C, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rreg(input int w, input int lane, input logic [5:0] r);
        return dut.oc_inst.rf_bank_phys[r[1:0]][lane][w][r[5:2]];
    endfunction

    task automatic wreg_all(input int w, input logic [5:0] r, input logic [31:0] v);
        for (int l = 0; l < 32; l++) dut.oc_inst.rf_bank_phys[r[1:0]][l][w][r[5:2]] = v;
    endtask

    task automatic clear_progs();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) dut.prog_mem[w][i] = enc(OP_EXIT, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called right after do_reset, before the first issuing edge.
    task automatic setup_warps(input int n, input logic [31:0] mask0);
        for (int w = 0; w < 24; w++) dut.warp_state[w] = (w < n) ? W_READY : W_EXIT;
        dut.warp_active_mask[0] = mask0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        clear_progs();
        do_reset();
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_cycle",  dut.cycle, 32'd0);
        check("rst_pc0",    32'(dut.warp_pc[0]), 32'd0);
        check("rst_state5", 32'(dut.warp_state[5]), 32'(W_READY));
        check("rst_mask",   dut.warp_active_mask[0], 32'hFFFF_FFFF);
        check("rst_writes", dut.warp_reg_writes[3], 32'd0);

        // ---------------- ALU ----------------
        clear_progs();
        dut.prog_mem[0][0]  = enc(OP_ADD, 1, 0, 0, 20'd5);
        dut.prog_mem[0][1]  = enc(OP_ADD, 2, 0, 0, 20'd3);
        dut.prog_mem[0][2]  = enc(OP_ADD, 10, 1, 2, 20'd0);
        dut.prog_mem[0][3]  = enc(OP_MUL, 11, 1, 2, 20'd0);
        dut.prog_mem[0][4]  = enc(OP_ADD, 3, 0, 0, 20'd13);
        dut.prog_mem[0][5]  = enc(OP_AND, 12, 3, 0, 20'd7);
        dut.prog_mem[0][6]  = enc(OP_XOR, 13, 1, 1, 20'd0);
        dut.prog_mem[0][7]  = enc(OP_ADD, 4, 0, 0, 20'd6);
        dut.prog_mem[0][8]  = enc(OP_SHL, 14, 4, 0, 20'd2);
        dut.prog_mem[0][9]  = enc(OP_ADD, 5, 0, 0, 20'd64);
        dut.prog_mem[0][10] = enc(OP_SHR, 15, 5, 0, 20'd3);
        dut.prog_mem[0][11] = enc(OP_TID, 16, 0, 0, 20'd0);
        dut.prog_mem[0][12] = enc(OP_ADD, 17, 0, 0, 20'hFFFFF);
        dut.prog_mem[0][13] = enc(8'h77, 10, 0, 0, 20'd1);
        wreg_all(0, 0, 32'd0);
        do_reset();
        setup_warps(1, 32'hFFFF_FFFF);
        wait_done("alu_done", 60);
        check("alu_add",   rreg(0, 0, 10), 32'd8);
        check("alu_mul",   rreg(0, 0, 11), 32'd15);
        check("alu_and",   rreg(0, 0, 12), 32'd5);
        check("alu_xor",   rreg(0, 0, 13), 32'd0);
        check("alu_shl",   rreg(0, 0, 14), 32'd24);
        check("alu_shr",   rreg(0, 7, 15), 32'd8);
        check("alu_tid0",  rreg(0, 0, 16), 32'd0);
        check("alu_tid5",  rreg(0, 5, 16), 32'd5);
        check("alu_tid31", rreg(0, 31, 16), 32'd31);
        check("alu_sext",  rreg(0, 2, 17), 32'hFFFF_FFFF);
        check("alu_nop",   rreg(0, 9, 10), 32'd8);
        check("alu_writes", dut.warp_reg_writes[0], 32'd13);
        check("alu_pc",    32'(dut.warp_pc[0]), 32'd15);

        // ---------------- barrier ordering ----------------
        clear_progs();
        dut.prog_mem[0][0] = enc(OP_ADD, 1, 0, 0, 20'hAB);
        dut.prog_mem[0][1] = enc(OP_STS, 0, 0, 1, 20'h40);
        dut.prog_mem[0][2] = enc(OP_BAR, 0, 0, 0, 20'd0);
        dut.prog_mem[1][0] = enc(OP_BAR, 0, 0, 0, 20'd0);
        dut.prog_mem[1][1] = enc(OP_LDS, 2, 0, 0, 20'h40);
        wreg_all(0, 0, 32'd0);
        wreg_all(1, 0, 32'd0);
        wreg_all(1, 2, 32'd0);
        dut.shared_mem[16] = 32'd0;
        do_reset();
        setup_warps(2, 32'hFFFF_FFFF);
        step(3);   // w0 ADD, w1 BAR, w0 STS
        check("bar_w1_wait",  32'(dut.warp_state[1]), 32'(W_BAR));
        check("bar_w1_pc",    32'(dut.warp_pc[1]), 32'd1);
        step(1);   // w0 BAR
        check("bar_w0_wait",  32'(dut.warp_state[0]), 32'(W_BAR));
        step(1);   // release
        check("bar_w1_free",  32'(dut.warp_state[1]), 32'(W_READY));
        check("bar_w0_free",  32'(dut.warp_state[0]), 32'(W_READY));
        wait_done("bar_done", 20);
        check("bar_lds_l0",  rreg(1, 0, 2), 32'h0000_00AB);
        check("bar_lds_l31", rreg(1, 31, 2), 32'h0000_00AB);

        // ---------------- active mask ----------------
        clear_progs();
        dut.prog_mem[0][0] = enc(OP_TID, 1, 0, 0, 20'd0);
        dut.prog_mem[0][1] = enc(OP_SHL, 2, 1, 0, 20'd2);
        dut.prog_mem[0][2] = enc(OP_STR, 0, 2, 1, 20'd1024);
        wreg_all(0, 1, 32'h5555);
        wreg_all(0, 2, 32'd0);
        for (int i = 0; i < 32; i++) dut.dut_memory.mem[8][i*32 +: 32] = 32'hD000_0000 + i;
        do_reset();
        setup_warps(1, 32'h0000_FFFF);
        wait_done("mask_done", 20);
        check("mask_w3",   dut.dut_memory.mem[8][3*32 +: 32],  32'd3);
        check("mask_w15",  dut.dut_memory.mem[8][15*32 +: 32], 32'd15);
        check("mask_w16",  dut.dut_memory.mem[8][16*32 +: 32], 32'hD000_0010);
        check("mask_w31",  dut.dut_memory.mem[8][31*32 +: 32], 32'hD000_001F);
        check("mask_reg20", rreg(0, 20, 1), 32'h5555);

        // ---------------- 8x8 tiled matmul ----------------
        clear_progs();
        for (int w = 0; w < 2; w++) begin
            logic [19:0] o;
            o = 20'(w * 128);
            dut.prog_mem[w][0] = enc(OP_TID, 1, 0, 0, 20'd0);
            dut.prog_mem[w][1] = enc(OP_SHL, 2, 1, 0, 20'd2);
            dut.prog_mem[w][2] = enc(OP_LDR, 4, 2, 0, o);
            dut.prog_mem[w][3] = enc(OP_STS, 0, 2, 4, o);
            dut.prog_mem[w][4] = enc(OP_LDR, 5, 2, 0, o + 20'd256);
            dut.prog_mem[w][5] = enc(OP_STS, 0, 2, 5, o + 20'd256);
            dut.prog_mem[w][6] = enc(OP_BAR, 0, 0, 0, 20'd0);
            dut.prog_mem[w][7] = enc(OP_ADD, 3, 2, 0, o);
            dut.prog_mem[w][8] = enc(OP_AND, 6, 3, 0, 20'hFFFE0);
            dut.prog_mem[w][9] = enc(OP_AND, 7, 3, 0, 20'd31);
            dut.prog_mem[w][10] = enc(OP_ADD, 8, 0, 0, 20'd0);
            for (int k = 0; k < 8; k++) begin
                dut.prog_mem[w][11+4*k] = enc(OP_LDS, 9, 6, 0, 20'(4*k));
                dut.prog_mem[w][12+4*k] = enc(OP_LDS, 10, 7, 0, 20'(256 + 32*k));
                dut.prog_mem[w][13+4*k] = enc(OP_MUL, 11, 9, 10, 20'd0);
                dut.prog_mem[w][14+4*k] = enc(OP_ADD, 8, 8, 11, 20'd0);
            end
            dut.prog_mem[w][43] = enc(OP_STR, 0, 3, 8, 20'd1024);
            wreg_all(w, 0, 32'd0);
        end
        for (int g = 0; g < 64; g++) begin
            dut.dut_memory.mem[g/32][(g%32)*32 +: 32]     = 32'(g + 1);
            dut.dut_memory.mem[2 + g/32][(g%32)*32 +: 32] = ((g/8) == (g%8)) ? 32'd1 : 32'd0;
            dut.dut_memory.mem[8 + g/32][(g%32)*32 +: 32] = 32'd0;
        end
        do_reset();
        setup_warps(2, 32'hFFFF_FFFF);
        wait_done("mm_done", 400);
        for (int g = 0; g < 64; g++) begin
            check($sformatf("mm_c%0d", g), dut.dut_memory.mem[8 + g/32][(g%32)*32 +: 32], 32'(g + 1));
        end
        check("mm_writes_w1", dut.warp_reg_writes[1], 32'd40);

        // ---------------- done / reset ----------------
        clear_progs();
        do_reset();
        setup_warps(2, 32'hFFFF_FFFF);
        step(2);   // both warps exit
        check("done_early", {31'd0, done}, 32'd0);
        step(1);
        check("done_set",   {31'd0, done}, 32'd1);
        check("done_cycle", dut.cycle, 32'd3);
        step(2);
        check("done_sticky", {31'd0, done}, 32'd1);
        rst = 1'b1;
        step(1);
        check("mrst_done",   {31'd0, done}, 32'd0);
        check("mrst_cycle",  dut.cycle, 32'd0);
        check("mrst_pc0",    32'(dut.warp_pc[0]), 32'd0);
        check("mrst_pc1",    32'(dut.warp_pc[1]), 32'd0);
        check("mrst_state9", 32'(dut.warp_state[9]), 32'(W_READY));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
